// File: rtl/sim_run_controller.sv
// sim_run_controller
//   Run controller for the simulation harness. It holds the harness in reset
//   for RESET_CYCLES cycles and counts cycles. It merges per-channel
//   success/fail status, enforces a global cycle timeout and a per-channel
//   progress watchdog, and gates waveform dumping to a cycle window.
//
// Ports
//   clock, reset      : clock, synchronous active-low reset
//   cfg_max_cycles    : global timeout (0 = disabled)
//   cfg_dump_start    : first cycle_count with dump enabled
//   cfg_dump_stop     : first cycle_count with dump disabled (0 = never)
//   cfg_watchdog      : per-channel idle limit (0 = disabled)
//   chan_success      : per-channel success level, accumulated sticky in RUN
//   chan_fail         : per-channel failure level
//   chan_progress     : per-channel progress pulse, clears the idle counter
//   dut_reset         : active-high reset to the harness
//   cycle_count       : cycles since reset release (saturating, frozen at end)
//   dump_en           : waveform dump window active
//   done/pass/fail    : sticky run status
//   fail_reason       : 0 none, 1 channel fail, 2 timeout, 3 watchdog
//   fail_chan         : offending channel (0 for timeout)
module sim_run_controller #(
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 64,
    parameter int WDOG_W       = 32,
    parameter int RESET_CYCLES = 16,
    parameter int DRAIN_CYCLES = 8,
    localparam int FC_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CNT_W-1:0]    cfg_max_cycles,
    input  logic [CNT_W-1:0]    cfg_dump_start,
    input  logic [CNT_W-1:0]    cfg_dump_stop,
    input  logic [WDOG_W-1:0]   cfg_watchdog,
    input  logic [CHANNELS-1:0] chan_success,
    input  logic [CHANNELS-1:0] chan_fail,
    input  logic [CHANNELS-1:0] chan_progress,
    output logic                dut_reset,
    output logic [CNT_W-1:0]    cycle_count,
    output logic                dump_en,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic [1:0]          fail_reason,
    output logic [FC_W-1:0]     fail_chan
);

    localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {S_HOLD, S_RUN, S_DRAIN, S_PASS, S_FAIL} state_t;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [CHANNELS-1:0]              mask_q, mask_d;
    logic [CHANNELS-1:0][WDOG_W-1:0]  idle_q, idle_d;
    logic [DR_W-1:0]                  drain_q, drain_d;
    logic [1:0]                       reason_q, reason_d;
    logic [FC_W-1:0]                  fchan_q, fchan_d;

    // Lowest-index channel selection for fail and watchdog reporting.
    logic            fail_any, wdog_any, timeout, all_succ;
    logic [FC_W-1:0] fail_idx, wdog_idx;

    always_comb begin
        fail_any = 1'b0;
        wdog_any = 1'b0;
        fail_idx = '0;
        wdog_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (chan_fail[i]) begin
                fail_any = 1'b1;
                fail_idx = FC_W'(i);
            end
            // Compare uses the registered idle value, so a progress pulse
            // arriving with the limit does not rescue the channel.
            if (cfg_watchdog != '0 && !mask_q[i] && idle_q[i] == cfg_watchdog) begin
                wdog_any = 1'b1;
                wdog_idx = FC_W'(i);
            end
        end
        timeout  = (cfg_max_cycles != '0) && (cnt_q >= cfg_max_cycles);
        all_succ = ((mask_q | chan_success) == '1);
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_HOLD;
            cnt_q    <= '0;
            mask_q   <= '0;
            idle_q   <= '0;
            drain_q  <= '0;
            reason_q <= '0;
            fchan_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            idle_q   <= idle_d;
            drain_q  <= drain_d;
            reason_q <= reason_d;
            fchan_q  <= fchan_d;
        end
    end

    // Next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        idle_d   = idle_q;
        drain_d  = drain_q;
        reason_d = reason_q;
        fchan_d  = fchan_q;
        case (state_q)
            S_HOLD: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) state_d = S_RUN;
            end
            S_RUN: begin
                mask_d = mask_q | chan_success;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (chan_progress[i])       idle_d[i] = '0;
                    else if (idle_q[i] != '1)   idle_d[i] = idle_q[i] + WDOG_W'(1);
                end
                if (fail_any) begin
                    state_d  = S_FAIL;
                    reason_d = 2'd1;
                    fchan_d  = fail_idx;
                end else if (timeout) begin
                    state_d  = S_FAIL;
                    reason_d = 2'd2;
                    fchan_d  = '0;
                end else if (wdog_any) begin
                    state_d  = S_FAIL;
                    reason_d = 2'd3;
                    fchan_d  = wdog_idx;
                end else if (all_succ) begin
                    state_d = (DRAIN_CYCLES == 0) ? S_PASS : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fail_any) begin
                    state_d  = S_FAIL;
                    reason_d = 2'd1;
                    fchan_d  = fail_idx;
                end else if (drain_q == DR_W'(DRAIN_CYCLES - 1)) begin
                    state_d = S_PASS;
                end else begin
                    drain_d = drain_q + DR_W'(1);
                end
            end
            default: ;
        endcase
        // Count only while the run continues, so the terminal edge freezes
        // the count at the value that triggered it.
        if (state_d != S_PASS && state_d != S_FAIL && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Outputs
    always_comb begin
        dut_reset   = (state_q == S_HOLD);
        pass        = (state_q == S_PASS);
        fail        = (state_q == S_FAIL);
        done        = pass | fail;
        dump_en     = !done && (cnt_q >= cfg_dump_start) &&
                      (cfg_dump_stop == '0 || cnt_q < cfg_dump_stop);
        cycle_count = cnt_q;
        fail_reason = reason_q;
        fail_chan   = fchan_q;
    end

endmodule

// File: tb/tb_sim_run_controller.sv
// tb_sim_run_controller
//   Scoreboard bench: each run pushes its expected terminal status when its
//   stimulus is set up, and pops/compares it when the DUT raises done.
module tb_sim_run_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] cfg_max_cycles = '0;
    logic [63:0] cfg_dump_start = '0;
    logic [63:0] cfg_dump_stop  = '0;
    logic [31:0] cfg_watchdog   = '0;
    logic [3:0]  chan_success   = '0;
    logic [3:0]  chan_fail      = '0;
    logic [3:0]  chan_progress  = '0;
    logic        dut_reset, dump_en, done, pass, fail;
    logic [63:0] cycle_count;
    logic [1:0]  fail_reason;
    logic [1:0]  fail_chan;

    sim_run_controller dut (
        .clock(clock), .reset(reset),
        .cfg_max_cycles(cfg_max_cycles), .cfg_dump_start(cfg_dump_start),
        .cfg_dump_stop(cfg_dump_stop), .cfg_watchdog(cfg_watchdog),
        .chan_success(chan_success), .chan_fail(chan_fail),
        .chan_progress(chan_progress),
        .dut_reset(dut_reset), .cycle_count(cycle_count), .dump_en(dump_en),
        .done(done), .pass(pass), .fail(fail),
        .fail_reason(fail_reason), .fail_chan(fail_chan)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        p;
        logic        f;
        logic [1:0]  r;
        logic [1:0]  c;
        longint      cnt;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string name);
        reset = 1'b0;
        chan_success = '0;
        chan_fail = '0;
        chan_progress = '0;
        step();
        step();
        check({name, ":rst_dut_reset"}, longint'(dut_reset), 1);
        check({name, ":rst_count"}, longint'(cycle_count), 0);
        check({name, ":rst_done"}, longint'(done), 0);
        check({name, ":rst_pass"}, longint'(pass), 0);
        check({name, ":rst_fail"}, longint'(fail), 0);
        check({name, ":rst_reason"}, longint'(fail_reason), 0);
        check({name, ":rst_chan"}, longint'(fail_chan), 0);
        check({name, ":rst_dump"}, longint'(dump_en), longint'(cfg_dump_start == 0));
        reset = 1'b1;
    endtask

    // t mirrors cycle_count: inputs driven at t are seen at the edge where
    // cycle_count==t. prog: 0 = all channels pulse every 10 cycles,
    // 1 = channels 0..2 pulse every cycle, channel 3 never.
    task automatic run_case(input string name, input int succ_at, input int ch3_at,
                            input int fail_at, input logic [3:0] fmask, input int prog,
                            input int abort_at, input bit chk_dump, input exp_t e);
        int   t;
        bit   seen;
        exp_t x;
        if (abort_at < 0) sb.push_back(e);
        t = 0;
        seen = 0;
        while (t < 2000) begin
            if (chk_dump) check({name, ":dump"}, longint'(dump_en), longint'(t >= 30 && t < 60));
            if (t == 15) check({name, ":dut_reset_hi"}, longint'(dut_reset), 1);
            if (t == 16) check({name, ":dut_reset_lo"}, longint'(dut_reset), 0);
            if (abort_at >= 0 && t == abort_at) return;
            chan_success = '0;
            if (succ_at >= 0 && t >= succ_at) chan_success[2:0] = 3'b111;
            if (ch3_at >= 0 && t >= ch3_at) chan_success[3] = 1'b1;
            chan_fail = (fail_at >= 0 && t >= fail_at) ? fmask : 4'b0000;
            if (prog == 1) chan_progress = 4'b0111;
            else chan_progress = (t % 10 == 0) ? 4'b1111 : 4'b0000;
            step();
            t++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            check({name, ":done_budget"}, 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        x = sb.pop_front();
        check({name, ":pass"}, longint'(pass), longint'(x.p));
        check({name, ":fail"}, longint'(fail), longint'(x.f));
        check({name, ":reason"}, longint'(fail_reason), longint'(x.r));
        check({name, ":chan"}, longint'(fail_chan), longint'(x.c));
        check({name, ":count"}, longint'(cycle_count), x.cnt);
        check({name, ":dump_end"}, longint'(dump_en), 0);
        chan_success = '0;
        chan_fail = '0;
        chan_progress = '0;
        step();
        step();
        check({name, ":count_frozen"}, longint'(cycle_count), x.cnt);
        check({name, ":done_sticky"}, longint'(done), 1);
        check({name, ":reason_hold"}, longint'(fail_reason), longint'(x.r));
    endtask

    initial begin
        exp_t none;
        none = '{1'b0, 1'b0, 2'd0, 2'd0, 0};

        do_reset("pass");
        run_case("pass", 100, 100, -1, 4'b0000, 0, -1, 0, '{1'b1, 1'b0, 2'd0, 2'd0, 108});

        do_reset("chfail");
        run_case("chfail", 50, 50, 50, 4'b0110, 0, -1, 0, '{1'b0, 1'b1, 2'd1, 2'd1, 50});

        cfg_max_cycles = 64'd200;
        do_reset("tmo");
        run_case("tmo", -1, -1, -1, 4'b0000, 0, -1, 0, '{1'b0, 1'b1, 2'd2, 2'd0, 200});
        cfg_max_cycles = '0;

        cfg_watchdog = 32'd20;
        do_reset("wdog");
        run_case("wdog", 21, -1, -1, 4'b0000, 1, -1, 0, '{1'b0, 1'b1, 2'd3, 2'd3, 36});
        do_reset("wdog_ok");
        run_case("wdog_ok", 21, 26, -1, 4'b0000, 1, -1, 0, '{1'b1, 1'b0, 2'd0, 2'd0, 34});
        cfg_watchdog = '0;

        cfg_dump_start = 64'd30;
        cfg_dump_stop  = 64'd60;
        cfg_max_cycles = 64'd80;
        do_reset("dump");
        run_case("dump", -1, -1, -1, 4'b0000, 0, -1, 1, '{1'b0, 1'b1, 2'd2, 2'd0, 80});
        cfg_dump_start = '0;
        cfg_dump_stop  = '0;
        cfg_max_cycles = '0;

        do_reset("abort");
        run_case("abort", 100, 100, -1, 4'b0000, 0, 104, 0, none);
        check("abort:in_drain_not_done", longint'(done), 0);
        do_reset("rerun");
        run_case("rerun", 100, 100, -1, 4'b0000, 0, -1, 0, '{1'b1, 1'b0, 2'd0, 2'd0, 108});

        check("sb_empty", longint'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
